ap_ctrl_txn_tracker: RTL and testbench

- Synthesizable, cycle-accurate tracker for one ap_ctrl_hs block-level handshake (ap_start/ap_ready/ap_done/ap_continue) of a non-dataflow HLS module.
- Turns the raw handshake into per-transaction records {start, ready, done timestamps, latency}, delivered on a valid/ready stream.
- Sits directly upstream of the module-status sampling and CSV dump path, which consumes its records instead of re-deriving them from level samples.
- One instance per monitored module.

---
 rtl/ap_ctrl_trk_pkg.sv | 36 +++
 rtl/ap_ctrl_txn_tracker_if.sv | 39 +++
 rtl/trk_sync_fifo.sv | 61 ++++++
 rtl/ap_ctrl_txn_tracker.sv | 230 +++++++++++++++++++++++
 tb/tb_ap_ctrl_txn_tracker.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ap_ctrl_trk_pkg.sv
// ---------------------------------------------------------------------------
// ap_ctrl_trk_pkg
// Shared types and default sizes for the ap_ctrl_hs transaction tracker.
//   TRK_TS_W        default timestamp width
//   TRK_PEND_DEPTH  default number of in-flight transactions
//   TRK_OUT_DEPTH   default record FIFO depth
//   TRK_CNT_W       default width of the record/drop counters
//   txn_rec_t       one completed transaction at the default timestamp width
//   fsm_e           run / drain / done control state
//   phase_e         input-side start/ready phase
// ---------------------------------------------------------------------------
package ap_ctrl_trk_pkg;

  localparam int TRK_TS_W       = 32;
  localparam int TRK_PEND_DEPTH = 4;
  localparam int TRK_OUT_DEPTH  = 8;
  localparam int TRK_CNT_W      = 16;

  typedef struct packed {
    logic [TRK_TS_W-1:0] startTs;
    logic [TRK_TS_W-1:0] readyTs;
    logic [TRK_TS_W-1:0] doneTs;
  } txn_rec_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } fsm_e;

  typedef enum logic {
    IDLE,
    WAIT
  } phase_e;

endpackage

// File: rtl/ap_ctrl_txn_tracker_if.sv
// ---------------------------------------------------------------------------
// ap_ctrl_txn_tracker_if
// Bundles the monitored ap_ctrl_hs handshake and the outgoing record stream.
//   ap_start/ap_ready/ap_done/ap_continue  monitored block-level handshake
//   rec_valid/rec_ready                    record stream handshake
//   rec_start_ts/rec_ready_ts/rec_done_ts  record timestamps
//   rec_latency                            done minus start, modulo 2^TS_W
// Modports:
//   master  drives the handshake and consumes records (environment side)
//   slave   observes the handshake and produces records (tracker side)
// ---------------------------------------------------------------------------
interface ap_ctrl_txn_tracker_if
  import ap_ctrl_trk_pkg::*;
#(
  parameter int TS_W = TRK_TS_W
) ();

  logic            ap_start;
  logic            ap_ready;
  logic            ap_done;
  logic            ap_continue;
  logic            rec_valid;
  logic            rec_ready;
  logic [TS_W-1:0] rec_start_ts;
  logic [TS_W-1:0] rec_ready_ts;
  logic [TS_W-1:0] rec_done_ts;
  logic [TS_W-1:0] rec_latency;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, rec_ready,
    input  rec_valid, rec_start_ts, rec_ready_ts, rec_done_ts, rec_latency
  );

  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, rec_ready,
    output rec_valid, rec_start_ts, rec_ready_ts, rec_done_ts, rec_latency
  );

endinterface

// File: rtl/trk_sync_fifo.sv
// ---------------------------------------------------------------------------
// trk_sync_fifo
// Single-clock first-word-fall-through FIFO.
//   clock, reset  clock and synchronous active-high reset
//   i_wrEn        write request (ignored when full unless a read frees a slot)
//   i_wrData      write data
//   i_rdEn        read/pop request (ignored when empty)
//   o_rdData      head entry, valid whenever o_empty is low
//   o_full        DEPTH entries held
//   o_empty       no entries held
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module trk_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_wrEn,
  input  logic [WIDTH-1:0] i_wrData,
  input  logic             i_rdEn,
  output logic [WIDTH-1:0] o_rdData,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_doWr;
  logic             w_doRd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doRd   = i_rdEn && !o_empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO
  // still lands when the head is leaving.
  assign w_doWr   = i_wrEn && (!o_full || w_doRd);
  assign o_rdData = r_mem[r_rdPtr[AW-1:0]];

  // Pointer registers; reset empties the FIFO without touching storage.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doWr) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doRd) r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (w_doWr) r_mem[r_wrPtr[AW-1:0]] <= i_wrData;
  end

endmodule

// File: rtl/ap_ctrl_txn_tracker.sv
// ---------------------------------------------------------------------------
// ap_ctrl_txn_tracker
// Turns one ap_ctrl_hs handshake into per-transaction timestamp records.
//   clock, reset     clock and synchronous active-high reset
//   bus (slave)      monitored ap_start/ap_ready/ap_done/ap_continue plus
//                    the FWFT record stream rec_valid/rec_ready/rec_*
//   finish           end-of-run request, level-sampled while running
//   txn_count        records written to the record FIFO (saturating)
//   drop_count       records lost to a full record FIFO (saturating)
//   err_orphan_done  sticky: done event with nothing in flight
//   err_pend_full    sticky: handshake lost because the pending queue was full
//   drained          finish seen and everything in flight delivered
// ---------------------------------------------------------------------------
module ap_ctrl_txn_tracker
  import ap_ctrl_trk_pkg::*;
#(
  parameter int TS_W       = TRK_TS_W,
  parameter int PEND_DEPTH = TRK_PEND_DEPTH,
  parameter int OUT_DEPTH  = TRK_OUT_DEPTH,
  parameter int CNT_W      = TRK_CNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  ap_ctrl_txn_tracker_if.slave bus,
  input  logic                 finish,
  output logic [CNT_W-1:0]     txn_count,
  output logic [CNT_W-1:0]     drop_count,
  output logic                 err_orphan_done,
  output logic                 err_pend_full,
  output logic                 drained
);

  typedef struct packed {
    logic [TS_W-1:0] startTs;
    logic [TS_W-1:0] readyTs;
  } pend_t;

  typedef struct packed {
    logic [TS_W-1:0] startTs;
    logic [TS_W-1:0] readyTs;
    logic [TS_W-1:0] doneTs;
  } rec_t;

  logic [TS_W-1:0] r_cyc;
  logic [TS_W-1:0] r_startTs;
  logic [TS_W-1:0] w_hsStart;
  fsm_e            r_fsm;
  fsm_e            w_fsmNext;
  phase_e          r_phase;
  phase_e          w_phaseNext;
  logic            w_accept;
  logic            w_hs;
  logic            w_latchStart;
  logic            w_doneEvt;
  logic            w_pendPush;
  logic            w_pendPop;
  logic            w_pendFull;
  logic            w_pendEmpty;
  logic            w_pendOverflow;
  logic            w_bypass;
  logic            w_orphan;
  logic            w_recWr;
  logic            w_recWrOk;
  logic            w_recDrop;
  logic            w_recPop;
  logic            w_recFull;
  logic            w_recEmpty;
  pend_t           w_pendIn;
  pend_t           w_pendHead;
  rec_t            w_recIn;
  rec_t            w_recHead;

  // Free-running cycle stamp; wraps silently.
  always_ff @(posedge clock) begin
    if (reset) r_cyc <= '0;
    else       r_cyc <= r_cyc + 1'b1;
  end

  // Run/drain/done state register.
  always_ff @(posedge clock) begin
    if (reset) r_fsm <= RUN;
    else       r_fsm <= w_fsmNext;
  end

  // Leave RUN on finish, then wait until nothing is in flight or buffered.
  // DONE is terminal until reset.
  always_comb begin
    w_fsmNext = r_fsm;
    case (r_fsm)
      RUN:     if (finish) w_fsmNext = DRAIN;
      DRAIN:   if (w_pendEmpty && w_recEmpty) w_fsmNext = DONE;
      DONE:    w_fsmNext = DONE;
      default: w_fsmNext = RUN;
    endcase
  end

  assign w_accept = (r_fsm == RUN);
  assign drained  = (r_fsm == DONE);

  // Input phase register plus the start timestamp held across WAIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase   <= IDLE;
      r_startTs <= '0;
    end else begin
      r_phase <= w_phaseNext;
      if (w_latchStart) r_startTs <= r_cyc;
    end
  end

  // Start/ready tracking. A start with ready in the same cycle is an
  // immediate handshake; otherwise the start cycle is remembered until ready
  // arrives or start drops (abort). Once running stops, any half-open start
  // is abandoned and new starts are ignored.
  always_comb begin
    w_phaseNext  = r_phase;
    w_hs         = 1'b0;
    w_hsStart    = r_startTs;
    w_latchStart = 1'b0;
    if (!w_accept) begin
      w_phaseNext = IDLE;
    end else begin
      case (r_phase)
        IDLE: begin
          if (bus.ap_start) begin
            if (bus.ap_ready) begin
              w_hs      = 1'b1;
              w_hsStart = r_cyc;
            end else begin
              w_phaseNext  = WAIT;
              w_latchStart = 1'b1;
            end
          end
        end
        WAIT: begin
          if (!bus.ap_start) begin
            w_phaseNext = IDLE;
          end else if (bus.ap_ready) begin
            w_hs        = 1'b1;
            w_phaseNext = IDLE;
          end
        end
        default: w_phaseNext = IDLE;
      endcase
    end
  end

  // Done pairing. The oldest pending entry is consumed first; with nothing
  // pending, a same-cycle handshake is paired directly instead of being
  // queued. A done with neither is an orphan.
  assign w_doneEvt      = bus.ap_done && bus.ap_continue;
  assign w_pendPop      = w_doneEvt && !w_pendEmpty;
  assign w_bypass       = w_doneEvt && w_pendEmpty && w_hs;
  assign w_orphan       = w_doneEvt && w_pendEmpty && !w_hs;
  assign w_pendOverflow = w_hs && !w_bypass && w_pendFull && !w_pendPop;
  assign w_pendPush     = w_hs && !w_bypass && !w_pendOverflow;

  assign w_pendIn.startTs = w_hsStart;
  assign w_pendIn.readyTs = r_cyc;

  // Record assembly on the done cycle, from either the queue head or the
  // bypassed handshake.
  always_comb begin
    w_recIn.doneTs = r_cyc;
    if (w_pendPop) begin
      w_recIn.startTs = w_pendHead.startTs;
      w_recIn.readyTs = w_pendHead.readyTs;
    end else begin
      w_recIn.startTs = w_hsStart;
      w_recIn.readyTs = r_cyc;
    end
  end

  assign w_recPop  = bus.rec_ready && !w_recEmpty;
  assign w_recWr   = w_pendPop || w_bypass;
  assign w_recDrop = w_recWr && w_recFull && !w_recPop;
  assign w_recWrOk = w_recWr && !w_recDrop;

  trk_sync_fifo #(
    .WIDTH ($bits(pend_t)),
    .DEPTH (PEND_DEPTH)
  ) u_pendQ (
    .clock    (clock),
    .reset    (reset),
    .i_wrEn   (w_pendPush),
    .i_wrData (w_pendIn),
    .i_rdEn   (w_pendPop),
    .o_rdData (w_pendHead),
    .o_full   (w_pendFull),
    .o_empty  (w_pendEmpty)
  );

  trk_sync_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (OUT_DEPTH)
  ) u_recQ (
    .clock    (clock),
    .reset    (reset),
    .i_wrEn   (w_recWrOk),
    .i_wrData (w_recIn),
    .i_rdEn   (w_recPop),
    .o_rdData (w_recHead),
    .o_full   (w_recFull),
    .o_empty  (w_recEmpty)
  );

  // Record fields are forced to zero while no record is presented so stale
  // FIFO storage never shows on the outputs.
  assign bus.rec_valid    = !w_recEmpty;
  assign bus.rec_start_ts = w_recEmpty ? '0 : w_recHead.startTs;
  assign bus.rec_ready_ts = w_recEmpty ? '0 : w_recHead.readyTs;
  assign bus.rec_done_ts  = w_recEmpty ? '0 : w_recHead.doneTs;
  assign bus.rec_latency  = w_recEmpty ? '0 : (w_recHead.doneTs - w_recHead.startTs);

  // Saturating record/drop counters and sticky protocol error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      txn_count       <= '0;
      drop_count      <= '0;
      err_orphan_done <= 1'b0;
      err_pend_full   <= 1'b0;
    end else begin
      if (w_recWrOk && (txn_count != {CNT_W{1'b1}}))  txn_count  <= txn_count + 1'b1;
      if (w_recDrop && (drop_count != {CNT_W{1'b1}})) drop_count <= drop_count + 1'b1;
      if (w_orphan)       err_orphan_done <= 1'b1;
      if (w_pendOverflow) err_pend_full   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_txn_tracker.sv
// ---------------------------------------------------------------------------
// tb_ap_ctrl_txn_tracker
// Self-checking bench for ap_ctrl_txn_tracker. Expected records are queued
// when the handshake is driven and compared as the tracker presents them.
// ---------------------------------------------------------------------------
module tb_ap_ctrl_txn_tracker;
  import ap_ctrl_trk_pkg::*;

  logic                 clock;
  logic                 reset;
  logic                 finish;
  logic [TRK_CNT_W-1:0] txn_count;
  logic [TRK_CNT_W-1:0] drop_count;
  logic                 err_orphan_done;
  logic                 err_pend_full;
  logic                 drained;
  logic [31:0]          tbCyc;
  int                   testsRun;
  int                   testsFailed;
  txn_rec_t             sb[$];

  ap_ctrl_txn_tracker_if bus ();

  ap_ctrl_txn_tracker #(
    .TS_W       (TRK_TS_W),
    .PEND_DEPTH (TRK_PEND_DEPTH),
    .OUT_DEPTH  (TRK_OUT_DEPTH),
    .CNT_W      (TRK_CNT_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus),
    .finish          (finish),
    .txn_count       (txn_count),
    .drop_count      (drop_count),
    .err_orphan_done (err_orphan_done),
    .err_pend_full   (err_pend_full),
    .drained         (drained)
  );

  // Clock generation.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected cycle stamp: at each falling edge this equals the stamp the
  // tracker will apply at the following rising edge.
  always @(posedge clock) begin
    if (reset) tbCyc <= '0;
    else       tbCyc <= tbCyc + 1;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: run still active at time %0t, limit 300000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic txn_rec_t mkRec(input logic [31:0] s, input logic [31:0] r,
                                     input logic [31:0] d);
    txn_rec_t t;
    t.startTs = s;
    t.readyTs = r;
    t.doneTs  = d;
    return t;
  endfunction

  task automatic applyStimulus(input logic st, input logic rd, input logic dn);
    bus.ap_start = st;
    bus.ap_ready = rd;
    bus.ap_done  = dn;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.ap_continue = 1'b1;
    bus.rec_ready   = 1'b1;
    finish          = 1'b0;
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic waitCyc(input logic [31:0] n);
    int guard;
    guard = 0;
    while (tbCyc != n && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    if (tbCyc != n) begin
      $display("[TB] FAIL wait_cyc: reached %0d, required %0d", tbCyc, n);
      $fatal(1, "[TB] stimulus schedule lost");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    finish = 1'b0;
    repeat (2) @(negedge clock);
    testsRun++;
    if (bus.rec_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_rec_valid: got %0b want 0", bus.rec_valid);
    end
    testsRun++;
    if ((bus.rec_start_ts | bus.rec_ready_ts | bus.rec_done_ts | bus.rec_latency) !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_rec_fields: got (%0d,%0d,%0d,%0d) want all 0",
               bus.rec_start_ts, bus.rec_ready_ts, bus.rec_done_ts, bus.rec_latency);
    end
    testsRun++;
    if (txn_count !== '0 || drop_count !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_counts: got txn %0d drop %0d want 0 0", txn_count, drop_count);
    end
    testsRun++;
    if ({err_orphan_done, err_pend_full, drained} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got orphan %0b full %0b drained %0b want 0 0 0",
               err_orphan_done, err_pend_full, drained);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    txn_rec_t exp;
    doReset();
    waitCyc(5);
    applyStimulus(1'b1, 1'b1, 1'b0);
    sb.push_back(mkRec(5, 5, 12));
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCyc(12);
    testsRun++;
    if (bus.rec_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_early: rec_valid got %0b want 0 before done", bus.rec_valid);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0);
    exp = sb.pop_front();
    testsRun++;
    if (bus.rec_valid !== 1'b1 || bus.rec_start_ts !== exp.startTs ||
        bus.rec_ready_ts !== exp.readyTs || bus.rec_done_ts !== exp.doneTs ||
        bus.rec_latency !== 32'd7) begin
      testsFailed++;
      $display("[TB] FAIL single_rec: got v%0b (%0d,%0d,%0d,%0d) want v1 (%0d,%0d,%0d,7)",
               bus.rec_valid, bus.rec_start_ts, bus.rec_ready_ts, bus.rec_done_ts,
               bus.rec_latency, exp.startTs, exp.readyTs, exp.doneTs);
    end
    testsRun++;
    if (txn_count !== 16'd1) begin
      testsFailed++;
      $display("[TB] FAIL single_txn_count: got %0d want 1", txn_count);
    end
    @(negedge clock);
    testsRun++;
    if (bus.rec_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_pop: rec_valid got %0b want 0 after pop", bus.rec_valid);
    end
  endtask

  task automatic test_bypass();
    txn_rec_t exp;
    doReset();
    waitCyc(3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCyc(6);
    applyStimulus(1'b1, 1'b1, 1'b1);
    sb.push_back(mkRec(3, 6, 6));
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0);
    exp = sb.pop_front();
    testsRun++;
    if (bus.rec_valid !== 1'b1 || bus.rec_start_ts !== exp.startTs ||
        bus.rec_ready_ts !== exp.readyTs || bus.rec_done_ts !== exp.doneTs ||
        bus.rec_latency !== 32'd3) begin
      testsFailed++;
      $display("[TB] FAIL bypass_rec: got v%0b (%0d,%0d,%0d,%0d) want v1 (%0d,%0d,%0d,3)",
               bus.rec_valid, bus.rec_start_ts, bus.rec_ready_ts, bus.rec_done_ts,
               bus.rec_latency, exp.startTs, exp.readyTs, exp.doneTs);
    end
    testsRun++;
    if (err_orphan_done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bypass_orphan: got %0b want 0", err_orphan_done);
    end
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0);
    testsRun++;
    if (err_orphan_done !== 1'b1 || bus.rec_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bypass_no_push: got orphan %0b valid %0b want 1 0",
               err_orphan_done, bus.rec_valid);
    end
  endtask

  task automatic test_pipelined();
    txn_rec_t    exp;
    logic [31:0] t0;
    doReset();
    bus.rec_ready = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      waitCyc(c);
      applyStimulus((c == 2 || c == 4 || c == 6), (c == 2 || c == 4 || c == 6), (c >= 10));
    end
    sb.push_back(mkRec(2, 2, 10));
    sb.push_back(mkRec(4, 4, 11));
    sb.push_back(mkRec(6, 6, 12));
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.rec_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      if (bus.rec_valid === 1'b1) begin
        exp = sb.pop_front();
        testsRun++;
        if (bus.rec_start_ts !== exp.startTs || bus.rec_ready_ts !== exp.readyTs ||
            bus.rec_done_ts !== exp.doneTs || bus.rec_latency !== exp.doneTs - exp.startTs) begin
          testsFailed++;
          $display("[TB] FAIL pipe_rec: got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)",
                   bus.rec_start_ts, bus.rec_ready_ts, bus.rec_done_ts, bus.rec_latency,
                   exp.startTs, exp.readyTs, exp.doneTs, exp.doneTs - exp.startTs);
        end
      end
      @(negedge clock);
    end
    testsRun++;
    if (sb.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL pipe_count: %0d records missing, want 0", sb.size());
      sb.delete();
    end
    // Fill the pending queue, then one more handshake overflows it.
    @(negedge clock);
    t0 = tbCyc;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clock);
    testsRun++;
    if (err_pend_full !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL pend_not_full: got %0b want 0 after 4 handshakes", err_pend_full);
    end
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0);
    testsRun++;
    if (err_pend_full !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pend_full: got %0b want 1 after 5th handshake", err_pend_full);
    end
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b1);
    sb.push_back(mkRec(t0, t0, t0 + 6));
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0);
    exp = sb.pop_front();
    testsRun++;
    if (bus.rec_valid !== 1'b1 || bus.rec_start_ts !== exp.startTs ||
        bus.rec_ready_ts !== exp.readyTs || bus.rec_done_ts !== exp.doneTs) begin
      testsFailed++;
      $display("[TB] FAIL pend_oldest: got v%0b (%0d,%0d,%0d) want v1 (%0d,%0d,%0d)",
               bus.rec_valid, bus.rec_start_ts, bus.rec_ready_ts, bus.rec_done_ts,
               exp.startTs, exp.readyTs, exp.doneTs);
    end
  endtask

  task automatic test_orphan();
    doReset();
    waitCyc(2);
    bus.ap_continue = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clock);
    testsRun++;
    if (err_orphan_done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL orphan_no_continue: got %0b want 0", err_orphan_done);
    end
    bus.ap_continue = 1'b1;
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0);
    testsRun++;
    if (err_orphan_done !== 1'b1 || bus.rec_valid !== 1'b0 || txn_count !== 16'd0) begin
      testsFailed++;
      $display("[TB] FAIL orphan_done: got orphan %0b valid %0b txn %0d want 1 0 0",
               err_orphan_done, bus.rec_valid, txn_count);
    end
  endtask

  task automatic test_backpressure();
    txn_rec_t    exp;
    logic [31:0] c;
    doReset();
    bus.rec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      c = tbCyc;
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (i < TRK_OUT_DEPTH) sb.push_back(mkRec(c, c, c + 1));
      @(negedge clock);
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0);
    testsRun++;
    if (drop_count !== 16'd2 || txn_count !== 16'd8) begin
      testsFailed++;
      $display("[TB] FAIL bp_counts: got drop %0d txn %0d want 2 8", drop_count, txn_count);
    end
    bus.rec_ready = 1'b1;
    for (int k = 0; k < 30 && sb.size() > 0; k++) begin
      if (bus.rec_valid === 1'b1) begin
        exp = sb.pop_front();
        testsRun++;
        if (bus.rec_start_ts !== exp.startTs || bus.rec_ready_ts !== exp.readyTs ||
            bus.rec_done_ts !== exp.doneTs || bus.rec_latency !== exp.doneTs - exp.startTs) begin
          testsFailed++;
          $display("[TB] FAIL bp_rec: got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)",
                   bus.rec_start_ts, bus.rec_ready_ts, bus.rec_done_ts, bus.rec_latency,
                   exp.startTs, exp.readyTs, exp.doneTs, exp.doneTs - exp.startTs);
        end
      end
      @(negedge clock);
    end
    testsRun++;
    if (sb.size() != 0 || bus.rec_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bp_drain: missing %0d valid %0b want 0 0", sb.size(), bus.rec_valid);
      sb.delete();
    end
  endtask

  task automatic test_finish();
    txn_rec_t exp;
    doReset();
    bus.rec_ready = 1'b0;
    waitCyc(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitCyc(4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCyc(5);
    finish = 1'b1;
    waitCyc(6);
    finish = 1'b0;
    waitCyc(7);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitCyc(8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCyc(10);
    applyStimulus(1'b0, 1'b0, 1'b1);
    sb.push_back(mkRec(2, 2, 10));
    sb.push_back(mkRec(3, 3, 11));
    waitCyc(12);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCyc(14);
    testsRun++;
    if (drained !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL finish_busy: drained got %0b want 0 with records held", drained);
    end
    bus.rec_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp = sb.pop_front();
      testsRun++;
      if (bus.rec_valid !== 1'b1 || bus.rec_start_ts !== exp.startTs ||
          bus.rec_ready_ts !== exp.readyTs || bus.rec_done_ts !== exp.doneTs) begin
        testsFailed++;
        $display("[TB] FAIL finish_rec: got v%0b (%0d,%0d,%0d) want v1 (%0d,%0d,%0d)",
                 bus.rec_valid, bus.rec_start_ts, bus.rec_ready_ts, bus.rec_done_ts,
                 exp.startTs, exp.readyTs, exp.doneTs);
      end
      @(negedge clock);
    end
    testsRun++;
    if (bus.rec_valid !== 1'b0 || drained !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL finish_empty: got valid %0b drained %0b want 0 0",
               bus.rec_valid, drained);
    end
    @(negedge clock);
    testsRun++;
    if (drained !== 1'b1 || txn_count !== 16'd2) begin
      testsFailed++;
      $display("[TB] FAIL finish_drained: got drained %0b txn %0d want 1 2", drained, txn_count);
    end
  endtask

  task automatic test_reset_discard();
    txn_rec_t exp;
    doReset();
    bus.rec_ready = 1'b0;
    waitCyc(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitCyc(3);
    applyStimulus(1'b1, 1'b1, 1'b1);
    sb.push_back(mkRec(2, 2, 3));
    waitCyc(4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    exp = sb.pop_front();
    testsRun++;
    if (bus.rec_valid !== 1'b1 || bus.rec_start_ts !== exp.startTs ||
        bus.rec_ready_ts !== exp.readyTs || bus.rec_done_ts !== exp.doneTs) begin
      testsFailed++;
      $display("[TB] FAIL pushpop_rec: got v%0b (%0d,%0d,%0d) want v1 (%0d,%0d,%0d)",
               bus.rec_valid, bus.rec_start_ts, bus.rec_ready_ts, bus.rec_done_ts,
               exp.startTs, exp.readyTs, exp.doneTs);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    testsRun++;
    if (bus.rec_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL discard_rec: rec_valid got %0b want 0 after reset", bus.rec_valid);
    end
    bus.rec_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0);
    testsRun++;
    if (err_orphan_done !== 1'b1 || bus.rec_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL discard_pend: got orphan %0b valid %0b want 1 0",
               err_orphan_done, bus.rec_valid);
    end
  endtask

  // Test sequence.
  initial begin
    testsRun        = 0;
    testsFailed     = 0;
    reset           = 1'b1;
    finish          = 1'b0;
    bus.ap_start    = 1'b0;
    bus.ap_ready    = 1'b0;
    bus.ap_done     = 1'b0;
    bus.ap_continue = 1'b1;
    bus.rec_ready   = 1'b1;
    @(negedge clock);
    test_reset();
    test_single();
    test_bypass();
    test_pipelined();
    test_orphan();
    test_backpressure();
    test_reset_discard();
    test_finish();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
